ex_stage: RTL and testbench

//  Execute stage of the 5-stage pipelined MIPS CPU (31-instruction subset).
//  - Latches the ID/EX pipeline register on each step clock.
//  - Computes the ALU result, zero flag and branch target combinationally from the latched values.
//  - Results feed mem_stage, which owns the EX/MEM register.
//  - Forwards the instruction type/number tags used by the pipeline LCD trace, plus two debug outputs.

---
 rtl/ex_stage.sv | 106 ++++++++++
 tb/tb_ex_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: latches ID/EX fields on each clk and derives ALU result, zero flag and branch target from them.
// Latency 1 cycle from ID inputs; no stall/flush, so every input is accepted every cycle.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_a_in,
  input  logic [31:0] id_b_in,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic        id_wmem,
  input  logic [5:0]  id_aluc,
  input  logic        id_aluimm,
  input  logic        id_shift,
  input  logic        id_branch,
  input  logic [31:0] id_pc4,
  input  logic [4:0]  id_destR,
  input  logic [3:0]  EX_ins_type,
  input  logic [3:0]  EX_ins_number,
  output logic        ex_wreg,
  output logic        ex_m2reg,
  output logic        ex_wmem,
  output logic [31:0] ex_aluR,
  output logic [31:0] ex_inB,
  output logic [4:0]  ex_destR,
  output logic        ex_branch,
  output logic [31:0] ex_pc,
  output logic        ex_zero,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number,
  output logic        LED1,
  output logic [31:0] temp_content
);

  logic [31:0] imm_q, a_q, pc4_q;
  logic [5:0]  aluc_q;
  logic        aluimm_q, shift_q;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q          <= '0;
      a_q            <= '0;
      ex_inB         <= '0;
      pc4_q          <= '0;
      aluc_q         <= '0;
      aluimm_q       <= 1'b0;
      shift_q        <= 1'b0;
      ex_wreg        <= 1'b0;
      ex_m2reg       <= 1'b0;
      ex_wmem        <= 1'b0;
      ex_destR       <= '0;
      ex_branch      <= 1'b0;
      MEM_ins_type   <= '0;
      MEM_ins_number <= '0;
    end else begin
      imm_q          <= id_imm;
      a_q            <= id_a_in;
      ex_inB         <= id_b_in;
      pc4_q          <= id_pc4;
      aluc_q         <= id_aluc;
      aluimm_q       <= id_aluimm;
      shift_q        <= id_shift;
      ex_wreg        <= id_wreg;
      ex_m2reg       <= id_m2reg;
      ex_wmem        <= id_wmem;
      ex_destR       <= id_destR;
      ex_branch      <= id_branch;
      MEM_ins_type   <= EX_ins_type;
      MEM_ins_number <= EX_ins_number;
    end
  end

  // Shift instructions take their count from the shamt field, not register A.
  assign op_a  = shift_q ? {27'b0, imm_q[10:6]} : a_q;
  assign op_b  = aluimm_q ? imm_q : ex_inB;
  assign shamt = op_a[4:0];

  always_comb begin
    ex_aluR = '0;
    case (aluc_q)
      6'd0:    ex_aluR = op_a + op_b;
      6'd1:    ex_aluR = op_a - op_b;
      6'd2:    ex_aluR = op_a & op_b;
      6'd3:    ex_aluR = op_a | op_b;
      6'd4:    ex_aluR = op_a ^ op_b;
      6'd5:    ex_aluR = ~(op_a | op_b);
      6'd6:    ex_aluR = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      6'd7:    ex_aluR = (op_a < op_b) ? 32'd1 : 32'd0;
      6'd8:    ex_aluR = op_b << shamt;
      6'd9:    ex_aluR = op_b >> shamt;
      6'd10:   ex_aluR = $signed(op_b) >>> shamt;
      6'd11:   ex_aluR = {op_b[15:0], 16'b0};
      6'd12:   ex_aluR = op_a + op_b;
      default: ex_aluR = '0;
    endcase
  end

  // Target is always computed; taken/not-taken is resolved downstream.
  assign ex_pc        = pc4_q + {imm_q[29:0], 2'b00};
  assign ex_zero      = (ex_aluR == 32'd0);
  assign LED1         = ex_zero;
  assign temp_content = {a_q[15:0], ex_inB[15:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases followed by random instructions checked against an arithmetic model.
module tb_ex_stage;

  typedef struct {
    logic [31:0] imm, a, b, pc4;
    logic        wreg, m2reg, wmem, aluimm, shift, branch;
    logic [5:0]  aluc;
    logic [4:0]  dest;
    logic [3:0]  typ, num;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_imm, id_a_in, id_b_in, id_pc4;
  logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_branch;
  logic [5:0]  id_aluc;
  logic [4:0]  id_destR;
  logic [3:0]  EX_ins_type, EX_ins_number;
  logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero, LED1;
  logic [31:0] ex_aluR, ex_inB, ex_pc, temp_content;
  logic [4:0]  ex_destR;
  logic [3:0]  MEM_ins_type, MEM_ins_number;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .id_imm(id_imm), .id_a_in(id_a_in), .id_b_in(id_b_in),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift),
    .id_branch(id_branch), .id_pc4(id_pc4), .id_destR(id_destR),
    .EX_ins_type(EX_ins_type), .EX_ins_number(EX_ins_number),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_destR(ex_destR),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_zero(ex_zero),
    .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
    .LED1(LED1), .temp_content(temp_content)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned pow2(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 2;
    return p;
  endfunction

  // Reference ALU written from the instruction semantics with plain arithmetic.
  function automatic logic [31:0] ref_alu(input stim_t s);
    longint unsigned ua, ub, p;
    longint          sa, sb;
    logic [31:0]     A, B;
    int              sh;
    A  = s.shift ? 32'(s.imm / 64) % 32 : s.a;
    B  = s.aluimm ? s.imm : s.b;
    ua = A; ub = B;
    sa = (ua >= 64'h8000_0000) ? longint'(ua) - longint'(64'h1_0000_0000) : longint'(ua);
    sb = (ub >= 64'h8000_0000) ? longint'(ub) - longint'(64'h1_0000_0000) : longint'(ub);
    sh = int'(ua % 32);
    p  = pow2(sh);
    case (int'(s.aluc))
      0, 12: return 32'((ua + ub) % 64'h1_0000_0000);
      1:     return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      2:     return A & B;
      3:     return A | B;
      4:     return A ^ B;
      5:     return ~(A | B);
      6:     return (sa < sb) ? 32'd1 : 32'd0;
      7:     return (ua < ub) ? 32'd1 : 32'd0;
      8:     return 32'((ub * p) % 64'h1_0000_0000);
      9:     return 32'(ub / p);
      10:    return (sb < 0) ? 32'(64'hFFFF_FFFF - ((64'hFFFF_FFFF - ub) / p)) : 32'(ub / p);
      11:    return 32'((ub % 65536) * 65536);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input stim_t s);
    logic [31:0] r;
    r = ref_alu(s);
    chk({tag, ".aluR"},   ex_aluR, r);
    chk({tag, ".zero"},   32'(ex_zero), (r == 0) ? 32'd1 : 32'd0);
    chk({tag, ".led1"},   32'(LED1), (r == 0) ? 32'd1 : 32'd0);
    chk({tag, ".pc"},     ex_pc, 32'((64'(s.pc4) + 64'(s.imm) * 4) % 64'h1_0000_0000));
    chk({tag, ".inB"},    ex_inB, s.b);
    chk({tag, ".ctrl"},   {28'b0, ex_wreg, ex_m2reg, ex_wmem, ex_branch},
                          {28'b0, s.wreg, s.m2reg, s.wmem, s.branch});
    chk({tag, ".dest"},   32'(ex_destR), 32'(s.dest));
    chk({tag, ".tags"},   {24'b0, MEM_ins_type, MEM_ins_number}, {24'b0, s.typ, s.num});
    chk({tag, ".debug"},  temp_content, (s.a % 65536) * 65536 + (s.b % 65536));
  endtask

  task automatic drive(input stim_t s);
    id_imm = s.imm; id_a_in = s.a; id_b_in = s.b; id_pc4 = s.pc4;
    id_wreg = s.wreg; id_m2reg = s.m2reg; id_wmem = s.wmem;
    id_aluimm = s.aluimm; id_shift = s.shift; id_branch = s.branch;
    id_aluc = s.aluc; id_destR = s.dest;
    EX_ins_type = s.typ; EX_ins_number = s.num;
  endtask

  // Present s before the next rising edge, then sample 1 time unit after it.
  task automatic step(input stim_t s);
    @(negedge clk);
    drive(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s.imm = 0; s.a = 0; s.b = 0; s.pc4 = 0;
    s.wreg = 0; s.m2reg = 0; s.wmem = 0; s.aluimm = 0; s.shift = 0; s.branch = 0;
    s.aluc = 0; s.dest = 0; s.typ = 0; s.num = 0;
    return s;
  endfunction

  initial begin
    stim_t s, z;
    z = zero_stim();
    s = z;
    s.a = 32'hFFFF_1111; s.b = 32'h2222_3333; s.imm = 32'h44; s.pc4 = 32'h500;
    s.aluc = 6'd3; s.wreg = 1; s.wmem = 1; s.branch = 1; s.dest = 5'd17; s.typ = 4'd5; s.num = 4'd6;
    drive(s);
    #2;
    check_all("reset", z);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("first", s);

    // Mid-cycle reset with nonzero inputs clears everything immediately.
    #2 rst = 1'b1;
    #1;
    check_all("midrst", z);
    chk("midrst.zero_lit", 32'(ex_zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("postrst", z);

    s = z; s.a = 5; s.b = 7; s.aluc = 0; s.wreg = 1; s.dest = 5'd3;
    step(s);
    check_all("add", s);
    chk("add.lit", ex_aluR, 32'd12);

    s = z; s.a = 32'h1234; s.b = 32'h1234; s.aluc = 1; s.branch = 1;
    s.pc4 = 32'h100; s.imm = 32'hFFFF_FFFE;
    step(s);
    check_all("beq", s);
    chk("beq.pc_lit", ex_pc, 32'h0000_00F8);

    s = z; s.b = 32'hDEAD; s.imm = 32'h0000_ABCD; s.aluimm = 1; s.aluc = 11;
    step(s);
    check_all("lui", s);
    chk("lui.lit", ex_aluR, 32'hABCD_0000);

    s = z; s.shift = 1; s.imm = 32'h0000_0100; s.b = 32'h8000_0010; s.a = 32'h1F;
    s.aluc = 10; step(s); check_all("sra", s); chk("sra.lit", ex_aluR, 32'hF800_0001);
    s.aluc = 9;  step(s); check_all("srl", s); chk("srl.lit", ex_aluR, 32'h0800_0001);
    s.aluc = 8;  step(s); check_all("sll", s); chk("sll.lit", ex_aluR, 32'h0000_0100);
    s.imm = 32'h0; s.aluc = 10; step(s); check_all("sra0", s);

    s = z; s.a = 32'hFFFF_FFFF; s.b = 1;
    s.aluc = 6; step(s); check_all("slt", s);  chk("slt.lit", ex_aluR, 32'd1);
    s.aluc = 7; step(s); check_all("sltu", s); chk("sltu.lit", ex_aluR, 32'd0);

    s = z; s.a = 32'hAAAA_1357; s.b = 32'h5555_2468; s.typ = 4'd3; s.num = 4'd9; s.aluc = 6'd13;
    step(s);
    check_all("tags", s);
    chk("tags.debug_lit", temp_content, 32'h1357_2468);

    for (int i = 0; i < 400; i++) begin
      s.a = $urandom; s.b = $urandom; s.imm = $urandom; s.pc4 = $urandom;
      if ($urandom_range(0, 3) == 0) s.b = s.a;
      if ($urandom_range(0, 1) == 0) s.imm = {{16{s.imm[15]}}, s.imm[15:0]};
      s.aluc = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) s.aluc = 6'($urandom_range(16, 63));
      s.aluimm = 1'($urandom); s.shift = 1'($urandom);
      s.wreg = 1'($urandom); s.m2reg = 1'($urandom); s.wmem = 1'($urandom); s.branch = 1'($urandom);
      s.dest = 5'($urandom); s.typ = 4'($urandom); s.num = 4'($urandom);
      step(s);
      check_all("rand", s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
